// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline control blocks: the hazard FSM state
// encoding, the register-index width, the default memory watchdog limit and
// the bundle of pipeline control strobes.
package pipe_pkg;

    localparam int unsigned REG_W       = 5;
    localparam int unsigned TIMEOUT_DEF = 64;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hz_state_e;

    // Control strobes driven into the PC, IF/ID and ID/EX registers.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic no_op;
        logic flush;
        logic freeze;
    } hz_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset, clears the count
//   inc_i  count this cycle
//   cnt_o  current count, holds at all-ones
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    // Count up, stopping at all-ones.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != {W{1'b1}})) begin
            cnt_o <= cnt_o + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the 5-stage core.
// Detects load-use hazards between ID and ID/EX, flushes IF/ID on taken
// branches, freezes the pipeline while a data memory access is outstanding
// and raises a sticky error if that access is never acknowledged.
// Optional build macro: HAZARD_PERF_EN adds stall/flush cycle counters.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   ID_Rs1_i, ID_Rs2_i    source registers of the ID instruction
//   ID_UseRs2_i           ID instruction reads rs2
//   EX_Rd_i, EX_MemRead_i destination and load flag of the ID/EX instruction
//   Branch_i              branch resolved taken in ID
//   DMemReq_i, DMemAck_i  data memory request in flight / completes
//   PCWrite_o, IFIDWrite_o, NoOp_o, Flush_o, Freeze_o  pipeline controls
//   Err_o                 sticky memory-timeout error
//   StallCnt_o, FlushCnt_o  perf counters (HAZARD_PERF_EN only)
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [REG_W-1:0] ID_Rs1_i,
    input  logic [REG_W-1:0] ID_Rs2_i,
    input  logic             ID_UseRs2_i,
    input  logic [REG_W-1:0] EX_Rd_i,
    input  logic             EX_MemRead_i,
    input  logic             Branch_i,
    input  logic             DMemReq_i,
    input  logic             DMemAck_i,
    output logic             PCWrite_o,
    output logic             IFIDWrite_o,
    output logic             NoOp_o,
    output logic             Flush_o,
    output logic             Freeze_o,
    output logic             Err_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] StallCnt_o,
    output logic [CNT_W-1:0] FlushCnt_o
`endif
);

    localparam int unsigned      WAIT_W   = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    hz_state_e         state_q;
    hz_state_e         state_d;
    logic [WAIT_W-1:0] wait_q;
    logic              err_q;
    logic              load_use;
    logic              mem_busy;
    hz_ctrl_t          ctrl;

    // x0 is never a real destination, so it cannot create a hazard.
    assign load_use = EX_MemRead_i && (EX_Rd_i != '0) &&
                      ((EX_Rd_i == ID_Rs1_i) || (ID_UseRs2_i && (EX_Rd_i == ID_Rs2_i)));
    assign mem_busy = DMemReq_i && !DMemAck_i;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and Mealy control outputs, in priority order.
    always_comb begin
        state_d         = state_q;
        ctrl            = '0;
        ctrl.pc_write   = 1'b1;
        ctrl.ifid_write = 1'b1;

        unique case (state_q)
            ST_RUN:      if (mem_busy)  state_d = ST_MEM_WAIT;
            ST_MEM_WAIT: if (DMemAck_i) state_d = ST_RUN;
            default:     state_d = ST_RUN;
        endcase

        if (rst_i) begin
            ctrl       = '0;
            ctrl.no_op = 1'b1;
        end else if ((state_q == ST_MEM_WAIT) ? !DMemAck_i : mem_busy) begin
            // Ack cycle falls through to the normal rows: no dead cycle.
            ctrl        = '0;
            ctrl.freeze = 1'b1;
        end else if (load_use) begin
            // Branch waits: its operands may come from the load.
            ctrl       = '0;
            ctrl.no_op = 1'b1;
        end else if (Branch_i) begin
            ctrl.flush = 1'b1;
        end
    end

    // Watchdog: counts unacknowledged MEM_WAIT cycles; error is sticky until reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else if (state_q == ST_RUN) begin
            wait_q <= '0;
        end else if (!DMemAck_i && (wait_q != WAIT_MAX)) begin
            wait_q <= wait_q + WAIT_W'(1);
            if (wait_q == WAIT_MAX - WAIT_W'(1)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign PCWrite_o   = ctrl.pc_write;
    assign IFIDWrite_o = ctrl.ifid_write;
    assign NoOp_o      = ctrl.no_op;
    assign Flush_o     = ctrl.flush;
    assign Freeze_o    = ctrl.freeze;
    assign Err_o       = err_q;

`ifdef HAZARD_PERF_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (ctrl.freeze || ctrl.no_op),
        .cnt_o (StallCnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (ctrl.flush),
        .cnt_o (FlushCnt_o)
    );
`else
    // Counter width only matters when the counters are built.
    logic unused_cnt_w;
    assign unused_cnt_w = ^32'(CNT_W);
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard/memory/timeout
// sequences followed by random traffic, all compared every cycle against a
// behavioural model of the controller's rules.
module tb_hazard_ctrl;

    localparam int unsigned TMO     = 4;
    localparam int unsigned CW      = 4;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs2, ex_mem_read, branch, dmem_req, dmem_ack;
    logic       pc_write, ifid_write, no_op, flush, freeze, err;
`ifdef HAZARD_PERF_EN
    logic [CW-1:0] stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ID_Rs1_i     (id_rs1),
        .ID_Rs2_i     (id_rs2),
        .ID_UseRs2_i  (id_use_rs2),
        .EX_Rd_i      (ex_rd),
        .EX_MemRead_i (ex_mem_read),
        .Branch_i     (branch),
        .DMemReq_i    (dmem_req),
        .DMemAck_i    (dmem_ack),
        .PCWrite_o    (pc_write),
        .IFIDWrite_o  (ifid_write),
        .NoOp_o       (no_op),
        .Flush_o      (flush),
        .Freeze_o     (freeze),
        .Err_o        (err)
`ifdef HAZARD_PERF_EN
        ,
        .StallCnt_o   (stall_cnt),
        .FlushCnt_o   (flush_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: waiting on memory, cycles waited, error, counters.
    bit m_waiting = 1'b0;
    int m_waited  = 0;
    bit m_err     = 1'b0;
    int m_stalls  = 0;
    int m_flushes = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected {pc_write, ifid_write, no_op, flush, freeze} from the control rules.
    function automatic logic [4:0] expect_ctrl();
        bit hold, hazard;
        if (rst) return 5'b00100;
        hold   = m_waiting ? !dmem_ack : (dmem_req && !dmem_ack);
        hazard = ex_mem_read && (ex_rd != 0) &&
                 (ex_rd == id_rs1 || (id_use_rs2 && ex_rd == id_rs2));
        if (hold)   return 5'b00001;
        if (hazard) return 5'b00100;
        if (branch) return 5'b11010;
        return 5'b11000;
    endfunction

    // Apply one cycle of inputs, check outputs mid-cycle, then advance the model.
    task automatic cyc(input string tag, input bit r, input logic [4:0] rs1, input logic [4:0] rs2,
                       input bit u2, input logic [4:0] rd, input bit mr, input bit br,
                       input bit rq, input bit ak);
        logic [4:0] e;
        rst = r; id_rs1 = rs1; id_rs2 = rs2; id_use_rs2 = u2; ex_rd = rd;
        ex_mem_read = mr; branch = br; dmem_req = rq; dmem_ack = ak;
        #3;
        e = expect_ctrl();
        check({tag, ".ctrl"}, 32'({pc_write, ifid_write, no_op, flush, freeze}), 32'(e));
        check({tag, ".err"}, 32'(err), 32'(m_err));
`ifdef HAZARD_PERF_EN
        check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stalls));
        check({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(m_flushes));
`endif
        @(posedge clk);
        if (r) begin
            m_waiting = 1'b0; m_waited = 0; m_err = 1'b0; m_stalls = 0; m_flushes = 0;
        end else begin
            if (e[0] || e[2]) m_stalls  = (m_stalls  < CNT_MAX) ? m_stalls + 1  : CNT_MAX;
            if (e[1])         m_flushes = (m_flushes < CNT_MAX) ? m_flushes + 1 : CNT_MAX;
            if (!m_waiting) begin
                if (rq && !ak) begin m_waiting = 1'b1; m_waited = 0; end
            end else if (ak) begin
                m_waiting = 1'b0;
            end else begin
                if (m_waited < int'(TMO)) m_waited++;
                if (m_waited == int'(TMO)) m_err = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 5'd1, 5'd2, 1'b1, 5'd0, 0, 0, 0, 0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        cyc("reset0", 1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0);
        cyc("reset1", 1, 5'd3, 5'd4, 1, 5'd3, 1, 1, 0, 0);
        idle("post_reset");

        // Load-use on rs1: one stall, then the bubble clears the load.
        cyc("lu_x5", 0, 5'd5, 5'd9, 0, 5'd5, 1, 0, 0, 0);
        cyc("lu_x5_next", 0, 5'd5, 5'd9, 0, 5'd5, 0, 0, 0, 0);
        cyc("lu_x0", 0, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0, 0);
        cyc("lu_rs2_unused", 0, 5'd1, 5'd7, 0, 5'd7, 1, 0, 0, 0);
        cyc("lu_rs2_used", 0, 5'd1, 5'd7, 1, 5'd7, 1, 0, 0, 0);

        // Load-use beats branch; the branch is taken on the retry.
        cyc("lu_branch", 0, 5'd3, 5'd0, 0, 5'd3, 1, 1, 0, 0);
        cyc("branch_retry", 0, 5'd3, 5'd0, 0, 5'd3, 0, 1, 0, 0);
        check("branch_retry.flush_seen", 32'(m_flushes > 0 || CNT_MAX == 0), 32'd1);

        // Three-cycle access acked in the third cycle.
        cyc("mem_c1", 0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 1, 0);
        check("mem_c1.waiting", 32'(freeze), 32'd1);
        cyc("mem_c2", 0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 1, 0);
        cyc("mem_c3_ack", 0, 5'd1, 5'd2, 0, 5'd0, 0, 1, 1, 1);
        idle("mem_done");
        cyc("req_ack_same", 0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 1, 1);
        idle("req_ack_after");
        cyc("stray_ack", 0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0, 1);
        idle("stray_ack_after");

        // Watchdog: never acked, error sets and stays until reset.
        for (int i = 0; i < 7; i++) cyc("timeout", 0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 1, 0);
        check("timeout.err_sticky", 32'(err), 32'd1);
        cyc("timeout_rst", 1, 5'd1, 5'd2, 0, 5'd0, 0, 0, 1, 0);
        idle("timeout_cleared");
        check("timeout.err_clear", 32'(err), 32'd0);

        // Reset mid-wait returns to RUN even without an ack.
        cyc("rst_wait_c1", 0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 1, 0);
        cyc("rst_wait_c2", 0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 1, 0);
        cyc("rst_wait_rst", 1, 5'd1, 5'd2, 0, 5'd0, 0, 0, 1, 0);
        idle("rst_wait_run");

        // Long run of taken branches drives the flush counter to saturation.
        for (int i = 0; i < 20; i++) cyc("flush_run", 0, 5'd1, 5'd2, 0, 5'd0, 0, 1, 0, 0);
`ifdef HAZARD_PERF_EN
        check("flush_run.saturated", 32'(flush_cnt), 32'(CNT_MAX));
`endif

        // Random traffic with small register numbers so hazards collide often.
        for (int i = 0; i < 3000; i++) begin
            cyc("random",
                ($urandom_range(99) < 2),
                5'($urandom_range(7)), 5'($urandom_range(7)), 1'($urandom),
                5'($urandom_range(7)), 1'($urandom),
                ($urandom_range(99) < 30),
                ($urandom_range(99) < 35),
                ($urandom_range(99) < 40));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
